// File: rtl/dcs_pkg.sv
// dcs_pkg: shared types and constants for the DCSformer requant/packer output stage.
//   pack_word_t - one packed FIFO entry (four int8 lanes, lane-valid mask, frame-last flag)
//   LANES       - int8 lanes per packed word
//   Q_MIN/Q_MAX - int8 saturation bounds
package dcs_pkg;

    localparam int LANES = 4;
    localparam int Q_MIN = -128;
    localparam int Q_MAX = 127;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } pack_word_t;

    // Lane-valid mask for a word whose highest filled lane is 'lane'.
    function automatic logic [3:0] keep_mask(input logic [1:0] lane);
        logic [3:0] m;
        case (lane)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dcs_requant_packer_if.sv
// dcs_requant_packer_if: stream bundle around the requant/packer.
//   in_valid/in_data/in_last/cfg_shift - result stream from the core (no backpressure)
//   out_valid/out_ready/out_data/out_keep/out_last - packed-word valid/ready stream
//   modport slave  - the packer side
//   modport master - the producer/consumer side (core + writeback)
interface dcs_requant_packer_if #(
    parameter int SHIFT_W = 5
);
    logic               in_valid;
    logic [31:0]        in_data;
    logic               in_last;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [3:0]         out_keep;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_last, cfg_shift, out_ready,
        input  out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, cfg_shift, out_ready,
        output out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/dcs_word_fifo.sv
// dcs_word_fifo: circular buffer of pack_word_t entries.
//   clk, rst   - clock, synchronous active-high reset
//   push/word  - write request and entry; accepted when not full or when a pop
//                happens in the same cycle (the pop frees the slot)
//   full       - occupancy == DEPTH
//   pop/empty  - read request (ignored when empty) and occupancy == 0
//   head       - oldest entry, combinational read
module dcs_word_fifo
    import dcs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pack_word_t push_word,
    output logic       full,
    input  logic       pop,
    output logic       empty,
    output pack_word_t head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pack_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end
endmodule

// File: rtl/dcs_requant_packer.sv
// dcs_requant_packer: requantizes the core's int32 results to int8 (arithmetic
// right shift, round half up, saturate), packs four bytes per 32-bit word and
// buffers words in a FIFO toward writeback.
//   clk, rst - clock, synchronous active-high reset
//   stream   - input result stream and output packed-word stream
//   ovf_err  - sticky: a completed word was dropped on a full FIFO
//   sat_cnt  - saturating count of clamped results
module dcs_requant_packer
    import dcs_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    dcs_requant_packer_if.slave  stream,
    output logic                 ovf_err,
    output logic [15:0]          sat_cnt
);
    localparam int LANE_W = $clog2(LANES);
    localparam logic signed [32:0] Q_HI = 33'(Q_MAX);
    localparam logic signed [32:0] Q_LO = 33'(Q_MIN);

    logic [SHIFT_W-1:0]  shift;
    logic signed [32:0]  x_ext;
    logic signed [32:0]  biased;
    logic signed [32:0]  shifted;
    logic                sat_hi;
    logic                sat_lo;
    logic [7:0]          q_byte;

    logic                r_valid;
    logic [7:0]          r_byte;
    logic                r_last;

    logic [LANE_W-1:0]   lane;
    logic [31:0]         acc_data;
    logic [31:0]         word_data;
    logic                complete;
    pack_word_t          push_word;
    pack_word_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;

    assign shift = stream.cfg_shift;

    // 33-bit datapath so adding the rounding bias to 0x7FFFFFFF cannot wrap.
    always_comb begin
        x_ext  = {stream.in_data[31], stream.in_data};
        biased = x_ext;
        if (shift != '0) biased = x_ext + (33'sd1 <<< (shift - 1'b1));
        shifted = biased >>> shift;
        sat_hi  = shifted > Q_HI;
        sat_lo  = shifted < Q_LO;
        if (sat_hi)      q_byte = 8'h7F;
        else if (sat_lo) q_byte = 8'h80;
        else             q_byte = shifted[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_byte  <= '0;
            r_last  <= 1'b0;
            sat_cnt <= '0;
        end else begin
            r_valid <= stream.in_valid;
            if (stream.in_valid) begin
                r_byte <= q_byte;
                r_last <= stream.in_last;
                if ((sat_hi || sat_lo) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    // Unfilled lanes of acc_data are always zero, so a short word needs no masking.
    always_comb begin
        word_data = acc_data;
        word_data[{lane, 3'b000} +: 8] = r_byte;
        complete  = r_valid && (lane == LANE_W'(LANES - 1) || r_last);
        push_word = '{data: word_data, keep: keep_mask(lane), last: r_last};
    end

    assign pop_fire = stream.out_valid && stream.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= '0;
            acc_data <= '0;
            ovf_err  <= 1'b0;
        end else if (r_valid) begin
            if (complete) begin
                lane     <= '0;
                acc_data <= '0;
                if (fifo_full && !pop_fire) ovf_err <= 1'b1;
            end else begin
                lane     <= lane + 1'b1;
                acc_data <= word_data;
            end
        end
    end

    dcs_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_word (push_word),
        .full      (fifo_full),
        .pop       (stream.out_ready),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Fields forced to zero when empty so stale memory never shows on the bus.
    assign stream.out_valid = !fifo_empty;
    assign stream.out_data  = fifo_empty ? 32'd0 : head.data;
    assign stream.out_keep  = fifo_empty ? 4'd0  : head.keep;
    assign stream.out_last  = fifo_empty ? 1'b0  : head.last;
endmodule

// File: tb/tb_dcs_requant_packer.sv
// tb_dcs_requant_packer: directed vectors for requant rounding/saturation and
// packing, plus hand-written sequences for short words, overflow, push/pop at
// full and reset mid-frame.
module tb_dcs_requant_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ovf_err;
    logic [15:0] sat_cnt;

    int tests  = 0;
    int failed = 0;
    int sat_exp = 0;

    dcs_requant_packer_if #(.SHIFT_W(5)) bus ();

    dcs_requant_packer #(.FIFO_DEPTH(4), .SHIFT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .stream  (bus),
        .ovf_err (ovf_err),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][31:0] x;
        logic [3:0][4:0]  s;
        logic [31:0]      word;
        int               sat_inc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] x, input logic [4:0] s, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.cfg_shift = s;
        bus.in_last   = last;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int k);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(4*k + i + 1);
        return w;
    endfunction

    task automatic send_word(input int k);
        for (int i = 0; i < 4; i++) send_beat(32'(4*k + i + 1), 5'd0, 1'b0);
    endtask

    task automatic expect_word(input string name, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (bus.out_valid) begin
            check({name, "_data"}, bus.out_data, d);
            check({name, "_keep"}, 32'(bus.out_keep), 32'(k));
            check({name, "_last"}, 32'(bus.out_last), 32'(l));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{x: {32'd7, 32'd5, 32'hFFFFFF9C, 32'd100}, s: {5'd0, 5'd0, 5'd0, 5'd0},
                    word: 32'h07059C64, sat_inc: 0};
        vecs[1] = '{x: {32'hFFFF63C0, 32'd40000, 32'hFFFFFFE8, 32'd24}, s: {5'd4, 5'd4, 5'd4, 5'd4},
                    word: 32'h807FFF02, sat_inc: 2};
        vecs[2] = '{x: {32'hFFFFFF00, 32'd255, 32'hFFFFFFFF, 32'd1}, s: {5'd1, 5'd1, 5'd1, 5'd1},
                    word: 32'h807F0001, sat_inc: 1};
        vecs[3] = '{x: {32'h40000000, 32'd0, 32'h80000000, 32'h7FFFFFFF}, s: {5'd31, 5'd31, 5'd31, 5'd31},
                    word: 32'h0100FF01, sat_inc: 0};
        vecs[4] = '{x: {32'hFFFF7F7F, 32'hFFFF8000, 32'd32640, 32'd32512}, s: {5'd8, 5'd8, 5'd8, 5'd8},
                    word: 32'h80807F7F, sat_inc: 2};
        vecs[5] = '{x: {32'd6, 32'd5, 32'd5, 32'd5}, s: {5'd2, 5'd2, 5'd1, 5'd0},
                    word: 32'h02010305, sat_inc: 0};

        idle(2);
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_keep", 32'(bus.out_keep), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);

        // Table: each vector is one full word with last on the 4th beat.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) send_beat(vecs[v].x[i], vecs[v].s[i], i == 3);
            check($sformatf("vec%0d_lat_pre", v), 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_lat_post", v), 32'(bus.out_valid), 32'd1);
            expect_word($sformatf("vec%0d", v), vecs[v].word, 4'b1111, 1'b1);
            sat_exp += vecs[v].sat_inc;
            check($sformatf("vec%0d_sat_cnt", v), 32'(sat_cnt), 32'(sat_exp));
        end

        // Six beats: full word then short final word.
        for (int i = 1; i <= 6; i++) send_beat(32'(i), 5'd0, i == 6);
        expect_word("six_w0", 32'h04030201, 4'b1111, 1'b0);
        expect_word("six_w1", 32'h00000605, 4'b0011, 1'b1);
        send_beat(32'd9, 5'd0, 1'b1);
        expect_word("last_lane0", 32'h00000009, 4'b0001, 1'b1);

        // Overflow: five words into a four-deep FIFO with no drain.
        do_reset();
        for (int k = 0; k < 4; k++) send_word(k);
        idle(2);
        check("ovf_before", 32'(ovf_err), 32'd0);
        send_word(4);
        idle(2);
        check("ovf_after", 32'(ovf_err), 32'd1);
        for (int k = 0; k < 4; k++) expect_word($sformatf("ovf_drain%0d", k), word_of(k), 4'b1111, 1'b0);
        check("ovf_drained", 32'(bus.out_valid), 32'd0);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Full FIFO with a pop in the very cycle the 5th word is pushed.
        do_reset();
        for (int k = 0; k < 4; k++) send_word(k);
        idle(2);
        send_word(4);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("full_pop_ovf", 32'(ovf_err), 32'd0);
        for (int k = 1; k < 5; k++) expect_word($sformatf("full_pop%0d", k), word_of(k), 4'b1111, 1'b0);
        check("full_pop_empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-frame: saturating partial word is discarded.
        send_beat(32'd1000, 5'd0, 1'b0);
        send_beat(32'd1000, 5'd0, 1'b0);
        idle(1);
        check("mid_sat_pre", 32'(sat_cnt), 32'd2);
        do_reset();
        check("mid_rst_sat", 32'(sat_cnt), 32'd0);
        check("mid_rst_ovf", 32'(ovf_err), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        send_beat(32'h11, 5'd0, 1'b0);
        send_beat(32'h22, 5'd0, 1'b0);
        send_beat(32'h33, 5'd0, 1'b0);
        send_beat(32'h44, 5'd0, 1'b1);
        expect_word("mid_fresh", 32'h44332211, 4'b1111, 1'b1);
        idle(3);
        check("mid_only_one", 32'(bus.out_valid), 32'd0);
        check("mid_sat_post", 32'(sat_cnt), 32'd0);
        check("mid_ovf_post", 32'(ovf_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/dcs_requant_packer.md
# dcs_requant_packer

Output stage placed directly downstream of the DCSformer core. It consumes the core's 32-bit signed result stream (`o_valid`/`o_data`), which has no backpressure. Each result is requantized to int8 by a programmable arithmetic right shift with round-half-up and saturation. Four consecutive bytes are packed into 32-bit words and buffered in a small FIFO that drains through a valid/ready interface to the writeback/DMA stage.

## Interface
- `FIFO_DEPTH`, 4: packed-word FIFO entries; must be a power of two, ≥2.
- `SHIFT_W`, 5: width of the requant shift amount.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high).
- `in_valid`  in  1  result beat valid; connected to core `o_valid`; no ready back.
- `in_data`  in  32  signed result; connected to core `o_data`.
- `in_last`  in  1  marks final result of a frame; qualified by `in_valid`.
- `cfg_shift`  in  SHIFT_W  right-shift amount, sampled with each beat.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head when `out_valid && out_ready`.
- `out_data`  out  32  packed bytes; lane k = bits [8k+7:8k]; lane 0 = oldest result.
- `out_keep`  out  4  lane-valid mask; `4'b1111` except on a short final word.
- `out_last`  out  1  word contains the frame's `in_last` result.
- `ovf_err`  out  1  sticky; set when a completed word is dropped because the FIFO is full.
- `sat_cnt`  out  16  count of saturated results; saturates at 16'hFFFF.

## Operation
- Requant (stage R):
  - s = `cfg_shift`. For s = 0, y = x. For s > 0, y = (x + 2^(s-1)) >>> s, computed at 33 bits so the bias cannot overflow.
  - Clamp to [-128, 127]. Each clamped result increments `sat_cnt`.
- Packer (stage P):
  - Lane counter `lane` runs 0..3. Each R-valid byte is written to lane `lane`, then `lane` increments.
  - A word completes when `lane` == 3 or the byte carries `last`.
  - On completion, push {data, keep, last} into the FIFO. Keep = one bit per filled lane (LSB-first; unfilled lanes hold 0). Then `lane` returns to 0.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - The push is dropped only if the FIFO is full and no pop occurs in the same cycle.
  - A dropped push sets `ovf_err`, which stays set until `rst`. The lane counter still resets to 0.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full and empty.
  - At full, the pop frees the slot the push uses.
- `in_last` with `lane` == 0 produces keep `4'b0001`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_keep` = 0, `out_last` = 0, `ovf_err` = 0, `sat_cnt` = 0.
  - FIFO empty, `lane` = 0, R stage invalid.
  - Reset mid-frame discards any partial word and all FIFO contents.
- Latency:
  - Beat sampled at edge E0 is registered in R at E0.
  - It is packed and, if completing, pushed at E1.
  - `out_valid` is high in the cycle after E1 (2 edges from the input sample) when the FIFO was empty.
- Throughput: one input beat per cycle sustained. Output can drain one word per cycle, so a 4:1 ratio leaves ample headroom.
- Output is FIFO-registered. `out_data`/`out_keep`/`out_last` are stable while `out_valid && !out_ready`.
- `cfg_shift` travels with its beat. Changes between beats take effect exactly on the next beat.

## Structure
- Package `dcs_pkg`:
  - `typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} pack_word_t`
  - constants `LANES = 4`, `Q_MIN = -128`, `Q_MAX = 127`.
- Sub-module `dcs_word_fifo`:
  - parameterized by depth, storing `pack_word_t`.
  - ports: push/full, pop/empty, head.
- Requant logic and packer stay in the top module.

## Test plan
- Reset then stream x = 100, -100, 5, 7 with shift 0 and in_last on the 4th beat -> one word `32'h0705_9C64`, keep `1111`, last 1, `out_valid` 2 edges after the 4th beat.
- Shift 4 on x = 24 (→2), x = -24 (→-1, round half up), x = 40000 (→127, sat), x = -40000 (→-128, sat) -> word `32'h807F_FF02`, `sat_cnt` = 2.
- Six beats with in_last on the 6th -> first word keep `1111` last 0; second word keep `0011` last 1, upper lanes 0.
- Hold `out_ready` = 0 and send 5 full words -> 4 words buffered, 5th dropped, `ovf_err` = 1. Raise `out_ready` -> exactly the 4 original words drain in order.
- FIFO full, and the cycle a word completes has `out_ready` = 1 -> push accepted, no overflow, occupancy stays 4.
- Assert `rst` after 2 beats of a word, then send 4 fresh beats -> only the fresh word is emitted, `sat_cnt` and `ovf_err` = 0.
